// File: rtl/alu_pkg.sv
// Shared definitions for the PID ALU and its control sequencer: source
// select codes, sequencer state type and the per-state control decode.
package alu_pkg;

  // src0 operand selects
  localparam logic [2:0] SRC0_A2D    = 3'b000;
  localparam logic [2:0] SRC0_INTGRL = 3'b001;
  localparam logic [2:0] SRC0_ICOMP  = 3'b010;
  localparam logic [2:0] SRC0_PCOMP  = 3'b011;
  localparam logic [2:0] SRC0_PTERM  = 3'b100;

  // src1 operand selects
  localparam logic [2:0] SRC1_ACCUM   = 3'b000;
  localparam logic [2:0] SRC1_ITERM   = 3'b001;
  localparam logic [2:0] SRC1_ERR     = 3'b010;
  localparam logic [2:0] SRC1_ERRDIV2 = 3'b011;
  localparam logic [2:0] SRC1_FWD     = 3'b100;

  // One state per control step, plus IDLE between passes.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_ERR   = 3'd1,
    S_INTG  = 3'd2,
    S_ICOMP = 3'd3,
    S_PCOMP = 3'd4,
    S_SUM1  = 3'd5,
    S_SUM2  = 3'd6
  } state_t;

  // Full set of ALU controls issued in one step.
  typedef struct packed {
    logic [2:0] src0sel;
    logic [2:0] src1sel;
    logic       multiply;
    logic       sub;
    logic       mult2;
    logic       mult4;
    logic       saturate;
  } alu_ctrl_t;

  // Fixed micro-op for each state; anything not listed stays 0.
  function automatic alu_ctrl_t ctrl_of(input state_t st);
    alu_ctrl_t c;
    c = '0;
    case (st)
      IDLE: c = '0;
      S_ERR: begin
        c.src0sel  = SRC0_A2D;
        c.src1sel  = SRC1_ACCUM;
        c.sub      = 1'b1;
        c.saturate = 1'b1;
      end
      S_INTG: begin
        c.src0sel  = SRC0_INTGRL;
        c.src1sel  = SRC1_ERRDIV2;
        c.saturate = 1'b1;
      end
      S_ICOMP: begin
        c.src0sel  = SRC0_INTGRL;
        c.src1sel  = SRC1_ITERM;
        c.multiply = 1'b1;
      end
      S_PCOMP: begin
        c.src0sel  = SRC0_PTERM;
        c.src1sel  = SRC1_ERR;
        c.multiply = 1'b1;
      end
      S_SUM1: begin
        c.src0sel  = SRC0_PCOMP;
        c.src1sel  = SRC1_FWD;
      end
      S_SUM2: begin
        c.src0sel  = SRC0_ICOMP;
        c.src1sel  = SRC1_ACCUM;
        c.saturate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Steps whose controls are held for several cycles.
  function automatic logic is_mult_step(input state_t st);
    logic m;
    case (st)
      S_ICOMP: m = 1'b1;
      S_PCOMP: m = 1'b1;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Control sequencer for the shared PID ALU. One pass per A2D sample walks
// the fixed micro-op list, captures the ALU result into the step's
// destination register and publishes the final 12-bit drive value.
module alu_seq
  import alu_pkg::*;
#(
  parameter int MULT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] setpoint,
  input  logic        clr_intgrl,
  input  logic        frz_intgrl,
  input  logic [15:0] dst,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [15:0] Icomp,
  output logic [11:0] Error,
  output logic [11:0] Intgrl,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic        busy,
  output logic        done,
  output logic [11:0] drive
);

  // Multiply steps hold for MULT_CYC cycles; counter reloads with this.
  localparam logic [2:0] MC_LOAD = 3'(MULT_CYC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic       w_cnt_zero;
  logic       w_capture;
  alu_ctrl_t  r_ctrl;
  logic       r_busy;
  logic       r_done;
  logic [15:0] r_accum;
  logic [15:0] r_pcomp;
  logic [15:0] r_icomp;
  logic [11:0] r_error;
  logic [11:0] r_intgrl;
  logic [11:0] r_drive;

  assign w_cnt_zero = (r_cnt == 3'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; w_capture marks the last cycle of a step.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      S_ERR: begin
        w_capture   = 1'b1;
        w_state_nxt = S_INTG;
      end
      S_INTG: begin
        w_capture   = 1'b1;
        w_state_nxt = S_ICOMP;
      end
      S_ICOMP: begin
        if (w_cnt_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = S_PCOMP;
        end else begin
          w_state_nxt = S_ICOMP;
        end
      end
      S_PCOMP: begin
        if (w_cnt_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SUM1;
        end else begin
          w_state_nxt = S_PCOMP;
        end
      end
      S_SUM1: begin
        w_capture   = 1'b1;
        w_state_nxt = S_SUM2;
      end
      S_SUM2: begin
        w_capture   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_capture   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Multiply hold counter: load on entry to a multiply step, count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if ((w_state_nxt != r_state) && is_mult_step(w_state_nxt)) begin
      r_cnt <= MC_LOAD;
    end else if (is_mult_step(r_state) && !w_cnt_zero) begin
      r_cnt <= r_cnt - 3'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Controls, busy and done registered from the upcoming state so they are
  // a clean function of the state register with no output glitching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ctrl <= ctrl_of(w_state_nxt);
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == S_SUM2) && w_capture;
    end
  end

  // Accum: loaded with the sign-extended setpoint on start, then summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accum <= 16'h0000;
    end else if ((r_state == IDLE) && start) begin
      r_accum <= {{4{setpoint[11]}}, setpoint};
    end else if (w_capture && ((r_state == S_SUM1) || (r_state == S_SUM2))) begin
      r_accum <= dst;
    end else begin
      r_accum <= r_accum;
    end
  end

  // Error capture at the end of S_ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 12'h000;
    end else if (w_capture && (r_state == S_ERR)) begin
      r_error <= dst[11:0];
    end else begin
      r_error <= r_error;
    end
  end

  // Integrator: clear beats everything, freeze only blocks the S_INTG update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_intgrl <= 12'h000;
    end else if (clr_intgrl) begin
      r_intgrl <= 12'h000;
    end else if (w_capture && (r_state == S_INTG) && !frz_intgrl) begin
      r_intgrl <= dst[11:0];
    end else begin
      r_intgrl <= r_intgrl;
    end
  end

  // Icomp / Pcomp captured on the final cycle of their multiply steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icomp <= 16'h0000;
      r_pcomp <= 16'h0000;
    end else begin
      if (w_capture && (r_state == S_ICOMP)) begin
        r_icomp <= dst;
      end else begin
        r_icomp <= r_icomp;
      end
      if (w_capture && (r_state == S_PCOMP)) begin
        r_pcomp <= dst;
      end else begin
        r_pcomp <= r_pcomp;
      end
    end
  end

  // Drive value published at the end of the pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drive <= 12'h000;
    end else if (w_capture && (r_state == S_SUM2)) begin
      r_drive <= dst[11:0];
    end else begin
      r_drive <= r_drive;
    end
  end

  assign Accum    = r_accum;
  assign Pcomp    = r_pcomp;
  assign Icomp    = r_icomp;
  assign Error    = r_error;
  assign Intgrl   = r_intgrl;
  assign drive    = r_drive;
  assign src0sel  = r_ctrl.src0sel;
  assign src1sel  = r_ctrl.src1sel;
  assign multiply = r_ctrl.multiply;
  assign sub      = r_ctrl.sub;
  assign mult2    = r_ctrl.mult2;
  assign mult4    = r_ctrl.mult4;
  assign saturate = r_ctrl.saturate;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
